// File: rtl/cpu_br_pkg.sv
// Shared types for branch resolution: branch op encoding, resolver FSM states
// and the default fall-through increment.
package cpu_br_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BGT  = 3'd4,
    BLE  = 3'd5,
    JMP  = 3'd6,
    RSVD = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } br_state_t;

  // Word-addressed PC: the next sequential instruction is one address up.
  localparam int PC_INC_DEF = 1;

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluator: maps op plus comparator flags to taken/op_err.
// Purely combinational, zero latency, no flow control.
module br_cond
  import cpu_br_pkg::*;
(
  input  br_op_t op,
  input  logic   eq,
  input  logic   gt,
  input  logic   lt,
  output logic   taken,
  output logic   op_err
);

  always_comb begin
    taken  = 1'b0;
    op_err = 1'b0;
    case (op)
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt;
      BGE:     taken = gt | eq;
      BGT:     taken = gt;
      BLE:     taken = lt | eq;
      JMP:     taken = 1'b1;
      default: op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: accept at N, outcome at N+1, redirect_valid at N+2 on mispredict.
// br_ready only in IDLE; redirect waits on redirect_ready, then flush for FLUSH_CYCLES.
module branch_resolve
  import cpu_br_pkg::*;
#(
  parameter int XLEN         = 16,
  parameter int PC_INC       = PC_INC_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_op,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  input  logic             pred_taken,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int FC_W = 4;

  br_state_t       state, state_nxt;
  br_op_t          op_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic            pred_q, eq_q, gt_q, lt_q;
  logic [FC_W-1:0] flush_cnt;

  logic            taken, op_err, flag_bad, mispred;
  logic [XLEN-1:0] target;

  br_cond u_cond (
    .op     (op_q),
    .eq     (eq_q),
    .gt     (gt_q),
    .lt     (lt_q),
    .taken  (taken),
    .op_err (op_err)
  );

  // Branch still resolves from raw flags; a malformed triple only raises the error.
  assign flag_bad = !$onehot({eq_q, gt_q, lt_q});
  assign mispred  = (taken != pred_q);
  assign target   = taken ? (pc_q + imm_q) : (pc_q + XLEN'(PC_INC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    br_ready       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state)
      IDLE: begin
        br_ready = !rst;
        if (br_valid && !rst) state_nxt = RESOLVE;
      end
      RESOLVE: state_nxt = mispred ? REDIRECT : IDLE;
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt <= FC_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= BEQ;
      pc_q        <= '0;
      imm_q       <= '0;
      pred_q      <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      redirect_pc <= '0;
      flush_cnt   <= '0;
      flag_err    <= 1'b0;
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      if (state == IDLE && br_valid) begin
        op_q   <= br_op_t'(br_op);
        pc_q   <= br_pc;
        imm_q  <= br_imm;
        pred_q <= pred_taken;
        eq_q   <= eq;
        gt_q   <= gt;
        lt_q   <= lt;
      end
      if (state == RESOLVE) begin
        if (mispred) redirect_pc <= target;
        if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
        if (mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
        if (op_err || flag_bad) flag_err <= 1'b1;
      end
      // Counter counts remaining flush cycles including the current one.
      if (state == REDIRECT && redirect_ready) flush_cnt <= FC_W'(FLUSH_CYCLES);
      else if (state == FLUSH)                flush_cnt <= flush_cnt - 1'b1;
    end
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Downstream consumer of the 16-bit magnitude comparator (`comp`): takes its combinational `eq`/`gt`/`lt` flags together with the branch op, PC and immediate.
- Resolves taken/not-taken and checks it against the fetch prediction.
- On a mispredict it issues a PC redirect under a valid/ready handshake, then holds a pipeline flush for a fixed number of cycles.
- Also keeps saturating taken and mispredict statistics counters.

Parameters:
- XLEN, 16, width of PC, immediate and redirect target.
- PC_INC, 1, fall-through increment (word-addressed PC).
- FLUSH_CYCLES, 2, cycles `flush` is held after a redirect is accepted; legal range 1..15.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  branch request valid.
- br_ready  out  1  block can accept a request.
- br_op  in  3  branch operation: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BGT, 5 BLE, 6 JMP, 7 reserved.
- br_pc  in  XLEN  PC of the branch.
- br_imm  in  XLEN  signed offset.
- pred_taken  in  1  fetch-stage prediction.
- eq, gt, lt  in  1 each  comparator flags, valid in the same cycle as br_valid.
- redirect_valid  out  1  redirect request.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  corrected next PC.
- flush  out  1  squash younger instructions.
- flag_err  out  1  sticky error flag.
- taken_cnt  out  CNT_W  saturating count of taken branches.
- mispred_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; redirect_valid=0, redirect_pc=0, flush=0, flag_err=0, taken_cnt=0, mispred_cnt=0; br_ready=0 while rst is high.
- Reset mid-operation aborts any redirect or flush in the same instant; no partial flush survives.
- States and transitions:
  - IDLE: br_ready=1. On br_valid&&br_ready, register op, pc, imm, pred_taken, eq, gt, lt, then go to RESOLVE.
  - RESOLVE (1 cycle): br_ready=0; evaluate the condition.
    - If taken!=pred_taken: register redirect_pc, go to REDIRECT.
    - Otherwise go to IDLE.
  - REDIRECT: redirect_valid=1 with redirect_pc held stable. Stay until redirect_ready=1. On the handshake cycle go to FLUSH and load the flush counter with FLUSH_CYCLES.
  - FLUSH: flush=1; decrement the counter each cycle; go to IDLE when the counter reaches 0.
    - flush is high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the handshake.
- Conditions:
  - BEQ: eq. BNE: !eq. BLT: lt. BGE: gt|eq. BGT: gt. BLE: lt|eq. JMP: 1.
  - Op 7: not taken, and sets flag_err.
- Target: taken → br_pc+br_imm; not taken → br_pc+PC_INC. Both are modulo 2^XLEN, so wrap-around is silent.
- Flag check: a registered flag triple that is not one-hot (all zero, or more than one set) sets flag_err (sticky until reset). The branch is still resolved from the raw flags.
- Counters:
  - taken_cnt increments in RESOLVE when taken.
  - mispred_cnt increments in RESOLVE on a mispredict.
  - Both saturate at all-ones; they never wrap.
- Latency, with the request accepted at cycle N:
  - outcome known at N+1;
  - on a mispredict, redirect_valid first high at N+2;
  - on a correct prediction, br_ready high again at N+2 (peak throughput of one branch per 2 cycles).
- br_valid while br_ready=0 is ignored; the upstream holds it.
- redirect_ready high outside REDIRECT is ignored.

Decomposition:
- Package cpu_br_pkg:
  - br_op_t enum (BEQ..JMP, RSVD);
  - br_state_t enum (IDLE, RESOLVE, REDIRECT, FLUSH);
  - PC_INC default constant.
- One combinational sub-module, br_cond: inputs op, eq, gt, lt; outputs taken and op_err. The top module holds the FSM, the target adder and the counters.

Test Plan:
- BEQ, pc=0x0010, imm=0x0020, eq=1, pred_taken=0 → redirect_valid at N+2 with redirect_pc=0x0030. With redirect_ready tied 1 → flush high for 2 cycles; mispred_cnt=1, taken_cnt=1.
- BLT, lt=0, gt=1, pred_taken=0 → no redirect, no flush; br_ready=1 at N+2; counters unchanged.
- BGE, pc=0xFFF0, imm=0x0020, eq=1, pred_taken=0 → redirect_pc=0x0010 (wrap). Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stay stable; flush stays 0 until the handshake.
- Flags eq=gt=1 with op BNE, or op=7 → flag_err=1 and stays 1 through later good branches.
- Assert rst asynchronously mid-FLUSH → flush, redirect_valid and the counters drop to 0 immediately; br_ready=1 the first cycle after release.
- Preload taken_cnt to 0xFFFE and issue 3 JMPs → taken_cnt saturates at 0xFFFF.
